// File: rtl/bus_arb_mux_if.sv
// Bus-side signal bundle for bus_arb_mux: sources, select/request controls and registered bus outputs.
// The master modport is the driver side; the slave modport is the bus_arb_mux side.
interface bus_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 25,
    parameter int SEL_W = 5
);
    logic [N_SRC*WIDTH-1:0] src_in;
    logic                   arb_mode;
    logic [SEL_W-1:0]       sel;
    logic                   sel_valid;
    logic [N_SRC-1:0]       req;
    logic                   lock;
    logic                   err_clr;
    logic [WIDTH-1:0]       bus_out;
    logic                   bus_valid;
    logic [N_SRC-1:0]       grant;
    logic                   sel_err;

    modport master (
        output src_in, arb_mode, sel, sel_valid, req, lock, err_clr,
        input  bus_out, bus_valid, grant, sel_err
    );

    modport slave (
        input  src_in, arb_mode, sel, sel_valid, req, lock, err_clr,
        output bus_out, bus_valid, grant, sel_err
    );
endinterface

// File: rtl/bus_arb_mux.sv
// Registered N-source bus multiplexer: direct 1-based select with sticky illegal-select flag,
// plus optional round-robin arbitration with lock, compiled in when BUS_ARB_MUX_RR_EN is defined.
module bus_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 25,
    parameter int SEL_W = 5
) (
    input logic          clk,
    input logic          clr,
    bus_arb_mux_if.slave bus
);
    logic [WIDTH-1:0] src_arr [N_SRC];

    logic [WIDTH-1:0] out_q, out_n;
    logic             valid_q, valid_n;
    logic [N_SRC-1:0] grant_q, grant_n;
    logic             err_q, err_n;

    logic             load;
    logic [31:0]      load_idx;
    logic [31:0]      sel_w;
    logic             sel_legal;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign src_arr[k] = bus.src_in[k*WIDTH +: WIDTH];
    end

    assign sel_w     = 32'(bus.sel);
    assign sel_legal = (sel_w >= 32'd1) && (sel_w <= 32'(N_SRC));

`ifdef BUS_ARB_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_n;
    logic [31:0]      ptr_w;
    logic             found;
    logic [31:0]      pick;
    logic [31:0]      best;
    logic [31:0]      dist;
    logic [31:0]      held_idx;
    logic [31:0]      ptr_next_w;
    logic             hold_lock;

    assign ptr_w     = 32'(ptr_q);
    assign hold_lock = bus.lock && (|(bus.req & grant_q));

    // Rotating priority: the requester at the smallest circular distance from ptr wins.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        best     = '0;
        dist     = '0;
        held_idx = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (bus.req[k]) begin
                dist = (k >= ptr_w) ? (k - ptr_w) : (k + 32'(N_SRC) - ptr_w);
                if (!found || dist < best) begin
                    found = 1'b1;
                    best  = dist;
                    pick  = k;
                end
            end
            if (grant_q[k]) begin
                held_idx = k;
            end
        end
        ptr_next_w = (pick == 32'(N_SRC - 1)) ? 32'd0 : pick + 32'd1;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{bus.arb_mode, bus.req, bus.lock};
`endif

    always_comb begin
        out_n    = out_q;
        valid_n  = 1'b0;
        grant_n  = '0;
        err_n    = err_q & ~bus.err_clr;
        load     = 1'b0;
        load_idx = '0;
`ifdef BUS_ARB_MUX_RR_EN
        ptr_n    = ptr_q;
        if (bus.arb_mode) begin
            if (hold_lock) begin
                load     = 1'b1;
                load_idx = held_idx;
            end else if (found) begin
                load     = 1'b1;
                load_idx = pick;
                ptr_n    = ptr_next_w[SEL_W-1:0];
            end
        end else
`endif
        if (bus.sel_valid) begin
            if (sel_legal) begin
                load     = 1'b1;
                load_idx = sel_w - 32'd1;
            end else begin
                out_n = '0;
                err_n = 1'b1;
            end
        end

        if (load) begin
            valid_n = 1'b1;
            for (int unsigned k = 0; k < N_SRC; k++) begin
                if (k == load_idx) begin
                    out_n      = src_arr[k];
                    grant_n[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            err_q   <= 1'b0;
`ifdef BUS_ARB_MUX_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            out_q   <= out_n;
            valid_q <= valid_n;
            grant_q <= grant_n;
            err_q   <= err_n;
`ifdef BUS_ARB_MUX_RR_EN
            ptr_q   <= ptr_n;
`endif
        end
    end

    assign bus.bus_out   = out_q;
    assign bus.bus_valid = valid_q;
    assign bus.grant     = grant_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Scoreboard bench for bus_arb_mux: directed vectors push expected results, a monitor compares them.
// Arbitration vectors are exercised when BUS_ARB_MUX_RR_EN is defined; otherwise mode inputs must be ignored.
module tb_bus_arb_mux;
    localparam int WIDTH = 32;
    localparam int N_SRC = 25;
    localparam int SEL_W = 5;

    typedef struct {
        int               cyc;
        int               id;
        logic [WIDTH-1:0] out;
        logic             valid;
        logic [N_SRC-1:0] grant;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   cyc = 0;
    int   step_id = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bus_arb_mux_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus_if ();

    bus_arb_mux #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    function automatic logic [WIDTH-1:0] src_val(input int k);
        if (k == 21) return 32'hDEAD_BEEF;
        if (k == 9)  return 32'h0000_1234;
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    function automatic logic [N_SRC-1:0] bit_of(input int k);
        logic [N_SRC-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step%0d got=%h exp=%h", name, id, got, exp);
        end
    endtask

    task automatic set_and_expect(input logic arb, input int sel, input logic sv,
                                  input logic [N_SRC-1:0] req, input logic lk, input logic eclr,
                                  input logic [WIDTH-1:0] e_out, input logic e_v, input int e_g, input logic e_err);
        exp_t e;
        bus_if.arb_mode  = arb;
        bus_if.sel       = SEL_W'(sel);
        bus_if.sel_valid = sv;
        bus_if.req       = req;
        bus_if.lock      = lk;
        bus_if.err_clr   = eclr;
        step_id++;
        e.cyc   = cyc + 1;
        e.id    = step_id;
        e.out   = e_out;
        e.valid = e_v;
        e.grant = bit_of(e_g);
        e.err   = e_err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic arb, input int sel, input logic sv,
                         input logic [N_SRC-1:0] req, input logic lk, input logic eclr,
                         input logic [WIDTH-1:0] e_out, input logic e_v, input int e_g, input logic e_err);
        @(negedge clk);
        set_and_expect(arb, sel, sv, req, lk, eclr, e_out, e_v, e_g, e_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bus_out"}, step_id, 64'(bus_if.bus_out), 64'd0);
        check({tag, "_bus_valid"}, step_id, 64'(bus_if.bus_valid), 64'd0);
        check({tag, "_grant"}, step_id, 64'(bus_if.grant), 64'd0);
        check({tag, "_sel_err"}, step_id, 64'(bus_if.sel_err), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("bus_out", e.id, 64'(bus_if.bus_out), 64'(e.out));
                check("bus_valid", e.id, 64'(bus_if.bus_valid), 64'(e.valid));
                check("grant", e.id, 64'(bus_if.grant), 64'(e.grant));
                check("sel_err", e.id, 64'(bus_if.sel_err), 64'(e.err));
            end
        end
    end

    initial begin : stimulus
        logic [N_SRC-1:0] none;
        logic [N_SRC-1:0] all;
        none = '0;
        all  = '1;
        for (int k = 0; k < N_SRC; k++) bus_if.src_in[k*WIDTH +: WIDTH] = src_val(k);
        bus_if.arb_mode  = 1'b0;
        bus_if.sel       = '0;
        bus_if.sel_valid = 1'b0;
        bus_if.req       = '0;
        bus_if.lock      = 1'b0;
        bus_if.err_clr   = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        clr = 1'b1;

        // direct mode
        drive(0, 22, 1, none, 0, 0, 32'hDEAD_BEEF, 1, 21, 0);
        drive(0, 1,  1, none, 0, 0, src_val(0),    1, 0,  0);
        drive(0, 25, 1, none, 0, 0, src_val(24),   1, 24, 0);
        drive(0, 3,  0, none, 0, 0, src_val(24),   0, -1, 0);
        drive(0, 0,  1, none, 0, 0, 32'd0,         0, -1, 1);
        drive(0, 27, 1, none, 0, 0, 32'd0,         0, -1, 1);
        drive(0, 26, 1, none, 0, 0, 32'd0,         0, -1, 1);
        drive(0, 5,  1, none, 0, 0, src_val(4),    1, 4,  1);
        drive(0, 0,  1, none, 0, 1, 32'd0,         0, -1, 1);
        drive(0, 3,  1, none, 0, 1, src_val(2),    1, 2,  0);
        drive(0, 3,  0, all,  1, 0, src_val(2),    0, -1, 0);

`ifdef BUS_ARB_MUX_RR_EN
        drive(1, 0, 1, bit_of(3) | bit_of(7) | bit_of(24), 0, 0, src_val(3),  1, 3,  0);
        drive(1, 0, 1, bit_of(3) | bit_of(7) | bit_of(24), 0, 0, src_val(7),  1, 7,  0);
        drive(1, 0, 1, bit_of(3) | bit_of(7) | bit_of(24), 0, 0, src_val(24), 1, 24, 0);
        drive(1, 0, 1, bit_of(3) | bit_of(7) | bit_of(24), 0, 0, src_val(3),  1, 3,  0);
        drive(1, 0, 0, bit_of(7) | bit_of(9), 1, 0, src_val(7), 1, 7, 0);
        drive(1, 0, 0, bit_of(7) | bit_of(9), 1, 0, src_val(7), 1, 7, 0);
        drive(1, 0, 0, bit_of(7) | bit_of(9), 1, 0, src_val(7), 1, 7, 0);
        drive(1, 0, 0, bit_of(9), 1, 0, 32'h0000_1234, 1, 9, 0);
        drive(1, 0, 0, none, 0, 0, 32'h0000_1234, 0, -1, 0);
        drive(1, 0, 0, none, 0, 0, 32'h0000_1234, 0, -1, 0);
        drive(1, 0, 0, none, 0, 0, 32'h0000_1234, 0, -1, 0);
        drive(0, 2, 1, bit_of(5) | bit_of(12), 0, 0, src_val(1),  1, 1,  0);
        drive(1, 2, 1, bit_of(5) | bit_of(12), 0, 0, src_val(12), 1, 12, 0);
        drive(1, 0, 0, bit_of(24), 0, 0, src_val(24), 1, 24, 0);
        drive(1, 0, 0, bit_of(5),  0, 0, src_val(5),  1, 5,  0);

        // asynchronous reset between edges with the pointer at 6
        @(posedge clk);
        #3;
        bus_if.req = bit_of(5) | bit_of(20);
        clr = 1'b0;
        #1;
        check_zero("async_clr");
        @(negedge clk);
        clr = 1'b1;
        set_and_expect(1, 0, 0, bit_of(5) | bit_of(20), 0, 0, src_val(5), 1, 5, 0);
        drive(1, 0, 0, bit_of(5) | bit_of(20), 0, 0, src_val(20), 1, 20, 0);
        drive(1, 0, 0, bit_of(5) | bit_of(20), 0, 0, src_val(5),  1, 5,  0);
`else
        drive(1, 4, 1, all, 1, 0, src_val(3), 1, 3,  0);
        drive(1, 0, 1, all, 0, 0, 32'd0,      0, -1, 1);
        drive(1, 0, 0, bit_of(5), 0, 0, 32'd0, 0, -1, 1);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
